// File: rtl/tube_pkg.sv
// Shared register map, CTRL field layout and seven-segment glyph table
// for the multiplexed tube display controller.
package tube_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;

    localparam int CTRL_MASK_LSB = 0;
    localparam int CTRL_LZS_BIT  = 8;
    localparam int CTRL_DEN_BIT  = 9;
    localparam int CTRL_BR_LSB   = 12;
    localparam int CTRL_DP_LSB   = 16;

    localparam logic [31:0] CTRL_RST   = 32'h0000_F2FF;
    // Only implemented CTRL bits survive a write; the rest read back as 0
    localparam logic [31:0] CTRL_WMASK = 32'h00FF_F3FF;

    // Active-low a..g patterns for hex digits 0..F
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low a..g segment pattern.
module seg7_hex_decode
    import tube_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = SEG7_TABLE[nibble];

endmodule

// File: rtl/tube_display_ctrl.sv
// Bus-mapped, time-multiplexed seven-segment controller with enable mask,
// decimal points, leading-zero suppression, PWM brightness and status readback.
module tube_display_ctrl
    import tube_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_7F30,
    parameter int          NUM_DIGITS = 8,
    parameter int          SCAN_DIV_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  WE,
    input  logic [3:0]            BE,
    input  logic [31:0]           Addr,
    input  logic [31:0]           Din,
    output logic [31:0]           Dout,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [7:0]            seg
);

    logic [31:0]           data;
    logic [31:0]           ctrl;
    logic [SCAN_DIV_W-1:0] dcnt;
    logic [2:0]            idx;
    logic                  cs;
    logic                  unused_addr_lsbs;

    assign cs               = (Addr[31:4] == BASE_ADDR[31:4]);
    assign unused_addr_lsbs = ^Addr[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] din,
                                                input logic [3:0]  be);
        merge_bytes = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) merge_bytes[8*k +: 8] = din[8*k +: 8];
    endfunction

    always_comb begin
        Dout = '0;
        if (cs) begin
            case (Addr[3:2])
                OFF_DATA:   Dout = data;
                OFF_CTRL:   Dout = ctrl;
                OFF_STATUS: Dout = {29'd0, idx};
                default:    Dout = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
            ctrl <= CTRL_RST;
        end else if (WE && cs) begin
            case (Addr[3:2])
                OFF_DATA: data <= merge_bytes(data, Din, BE);
                OFF_CTRL: ctrl <= merge_bytes(ctrl, Din, BE) & CTRL_WMASK;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt <= '0;
            idx  <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
            if (&dcnt)
                idx <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
        end
    end

    // above_nz[i]: some displayed nibble at position i or higher is non-zero
    logic [7:0] nz;
    logic [7:0] above_nz;

    always_comb begin
        nz       = '0;
        above_nz = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            nz[i] = |data[4*i +: 4];
        for (int i = 7; i >= 0; i--)
            above_nz[i] = nz[i] | ((i < 7) ? above_nz[(i < 7) ? i + 1 : i] : 1'b0);
    end

    logic [7:0] en_mask;
    logic [7:0] dp_mask;
    logic [7:0] onehot;
    logic [3:0] ph;
    logic [3:0] br;
    logic [3:0] nib;
    logic [6:0] hex;
    logic       suppressed;
    logic       lit;

    assign en_mask    = ctrl[CTRL_MASK_LSB +: 8];
    assign dp_mask    = ctrl[CTRL_DP_LSB +: 8];
    assign br         = ctrl[CTRL_BR_LSB +: 4];
    assign ph         = dcnt[SCAN_DIV_W-1 -: 4];
    assign nib        = data[{idx, 2'b00} +: 4];
    assign onehot     = 8'b1 << idx;
    assign suppressed = ctrl[CTRL_LZS_BIT] && (idx != 3'd0) && !above_nz[idx];
    assign lit        = ctrl[CTRL_DEN_BIT] && en_mask[idx] && (ph <= br) && !suppressed;

    seg7_hex_decode u_dec (
        .nibble (nib),
        .segs   (hex)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_sel <= '0;
            seg       <= 8'hFF;
        end else if (lit) begin
            digit_sel <= onehot[NUM_DIGITS-1:0];
            seg       <= {~dp_mask[idx], hex};
        end else begin
            digit_sel <= '0;
            seg       <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_tube_display_ctrl.sv
// Directed bench for tube_display_ctrl with a 16-clock dwell per digit.
module tb_tube_display_ctrl;

    localparam logic [31:0] A_DATA = 32'h0000_7F30;
    localparam logic [31:0] A_CTRL = 32'h0000_7F34;
    localparam logic [31:0] A_STAT = 32'h0000_7F38;
    localparam logic [31:0] A_RSVD = 32'h0000_7F3C;
    localparam logic [31:0] A_OUT  = 32'h0000_7F40;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        WE    = 1'b0;
    logic [3:0]  BE    = 4'h0;
    logic [31:0] Addr  = 32'h0;
    logic [31:0] Din   = 32'h0;
    logic [31:0] Dout;
    logic [7:0]  digit_sel;
    logic [7:0]  seg;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;

    always #5 clk = ~clk;

    tube_display_ctrl #(
        .BASE_ADDR  (32'h0000_7F30),
        .NUM_DIGITS (8),
        .SCAN_DIV_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .WE        (WE),
        .BE        (BE),
        .Addr      (Addr),
        .Din       (Din),
        .Dout      (Dout),
        .digit_sel (digit_sel),
        .seg       (seg)
    );

    // Rising edges since reset release; outputs after edge k show scan state k-1
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        Addr = a;
        BE   = be;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
        BE = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = Dout;
    endtask

    task automatic wait_out(input int d, input int p);
        int n;
        n = 0;
        @(negedge clk);
        while (!(edges >= 1 && ((edges - 1) % 16) == p && (((edges - 1) / 16) % 8) == d) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check_val("wait_timeout", 32'(n), 32'(0));
    endtask

    task automatic count_lit(output int cnt);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (digit_sel != 8'h00) cnt++;
        end
    endtask

    initial begin
        logic [31:0] r;
        int          cnt;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_sel", 32'(digit_sel), 32'h00);
        check_val("rst_seg", 32'(seg), 32'hFF);
        bus_read(A_DATA, r); check_val("rst_data", r, 32'h0);
        bus_read(A_CTRL, r); check_val("rst_ctrl", r, 32'h0000_F2FF);
        bus_read(A_STAT, r); check_val("rst_status", r, 32'h0);

        reset = 1'b0;
        @(negedge clk);
        check_val("first_sel", 32'(digit_sel), 32'h01);
        check_val("first_seg", 32'(seg), 32'h81);

        for (int d = 0; d < 8; d++) begin
            wait_out(d, 0);
            check_val($sformatf("scan_d%0d_start", d), 32'(digit_sel), 32'(8'h01 << d));
            wait_out(d, 15);
            check_val($sformatf("scan_d%0d_end", d), 32'(digit_sel), 32'(8'h01 << d));
        end

        bus_write(A_CTRL, 4'hF, 32'h0000_F3FF);
        wait_out(0, 5);
        check_val("lzs0_d0_sel", 32'(digit_sel), 32'h01);
        check_val("lzs0_d0_seg", 32'(seg), 32'h81);
        wait_out(3, 5);
        check_val("lzs0_d3_sel", 32'(digit_sel), 32'h00);
        check_val("lzs0_d3_seg", 32'(seg), 32'hFF);

        bus_write(A_DATA, 4'b0011, 32'h1234_ABCD);
        bus_read(A_DATA, r); check_val("be_data", r, 32'h0000_ABCD);
        wait_out(0, 2);
        check_val("abcd_d0_sel", 32'(digit_sel), 32'h01);
        check_val("abcd_d0_seg", 32'(seg), 32'hC2);
        wait_out(3, 2);
        check_val("abcd_d3_sel", 32'(digit_sel), 32'h08);
        check_val("abcd_d3_seg", 32'(seg), 32'h88);
        wait_out(4, 2);
        check_val("abcd_d4_sel", 32'(digit_sel), 32'h00);

        bus_write(A_DATA, 4'hF, 32'h0000_00F0);
        wait_out(0, 1);
        check_val("f0_d0_seg", 32'(seg), 32'h81);
        wait_out(1, 1);
        check_val("f0_d1_sel", 32'(digit_sel), 32'h02);
        check_val("f0_d1_seg", 32'(seg), 32'hB8);
        wait_out(2, 1);
        check_val("f0_d2_sel", 32'(digit_sel), 32'h00);
        check_val("f0_d2_seg", 32'(seg), 32'hFF);
        wait_out(7, 1);
        check_val("f0_d7_sel", 32'(digit_sel), 32'h00);
        bus_write(A_CTRL, 4'hF, 32'h0000_F2FF);
        wait_out(7, 1);
        check_val("nolzs_d7_sel", 32'(digit_sel), 32'h80);
        check_val("nolzs_d7_seg", 32'(seg), 32'h81);

        bus_write(A_CTRL, 4'hF, 32'h0000_32FF);
        wait_out(2, 3);
        check_val("br3_ph3_sel", 32'(digit_sel), 32'h04);
        check_val("br3_ph3_seg", 32'(seg), 32'h81);
        wait_out(2, 4);
        check_val("br3_ph4_sel", 32'(digit_sel), 32'h00);
        check_val("br3_ph4_seg", 32'(seg), 32'hFF);
        wait_out(5, 0);
        count_lit(cnt);
        check_val("br3_duty", 32'(cnt), 32'd4);
        bus_write(A_CTRL, 4'hF, 32'h0000_02FF);
        wait_out(6, 0);
        count_lit(cnt);
        check_val("br0_duty", 32'(cnt), 32'd1);

        bus_write(A_CTRL, 4'hF, 32'h0001_F2FE);
        wait_out(0, 0);
        count_lit(cnt);
        check_val("mask_d0_duty", 32'(cnt), 32'd0);
        wait_out(1, 3);
        check_val("dp_d1_seg", 32'(seg), 32'hB8);
        wait_out(3, 7);
        bus_read(A_STAT, r); check_val("status_idx3", r, 32'd3);
        wait_out(4, 3);
        check_val("dp_d4_seg", 32'(seg), 32'h81);
        bus_write(A_CTRL, 4'hF, 32'h0002_F2FF);
        wait_out(1, 3);
        check_val("dp_on_d1_seg", 32'(seg), 32'h38);

        bus_write(A_CTRL, 4'hF, 32'hFFFF_FFFF);
        bus_read(A_CTRL, r); check_val("ctrl_wmask", r, 32'h00FF_F3FF);
        bus_write(A_DATA, 4'h0, 32'hFFFF_FFFF);
        bus_read(A_DATA, r); check_val("be0_data", r, 32'h0000_00F0);
        bus_write(A_OUT, 4'hF, 32'h1234_5678);
        bus_read(A_DATA, r); check_val("outwin_wr_data", r, 32'h0000_00F0);
        bus_read(A_OUT, r); check_val("outwin_rd", r, 32'h0);
        bus_read(A_RSVD, r); check_val("rsvd_rd", r, 32'h0);

        bus_write(A_CTRL, 4'hF, 32'h0000_F2FF);
        wait_out(5, 6);
        check_val("pre_rst_sel", 32'(digit_sel), 32'h20);
        check_val("pre_rst_seg", 32'(seg), 32'h81);
        reset = 1'b1;
        #1;
        check_val("async_rst_sel", 32'(digit_sel), 32'h00);
        check_val("async_rst_seg", 32'(seg), 32'hFF);
        bus_read(A_CTRL, r); check_val("async_rst_ctrl", r, 32'h0000_F2FF);
        bus_read(A_DATA, r); check_val("async_rst_data", r, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_out(0, 0);
        check_val("resume_d0_sel", 32'(digit_sel), 32'h01);
        check_val("resume_d0_seg", 32'(seg), 32'h81);
        bus_read(A_STAT, r); check_val("resume_status", r, 32'd0);
        wait_out(1, 0);
        check_val("resume_d1_sel", 32'(digit_sel), 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
